dma_priority_arbiter: RTL and testbench

Channel priority arbiter and bus-request sequencer for the 4-channel DMA controller. Collects unmasked DREQ lines, raises HRQ to the CPU, and on HLDA grants exactly one channel via one-hot DACK. Holds the grant until EOP_N, request withdrawal or mask, then releases the bus. The timing-control state machine consumes `activeChannel`/`grantValid` to select the channel's address/count registers.

---
 rtl/dma_arb_pkg.sv | 12 +
 rtl/dma_priority_encoder.sv | 30 +++
 rtl/dma_priority_arbiter.sv | 121 ++++++++++++
 tb/tb_dma_priority_arbiter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/dma_arb_pkg.sv
// Shared types and sizing for the 4-channel DMA priority arbiter.
package dma_arb_pkg;
    localparam int CHANNELS = 4;
    localparam int SEL_W    = $clog2(CHANNELS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        GRANT   = 2'd2,
        RELEASE = 2'd3
    } arbState_t;
endpackage

// File: rtl/dma_priority_encoder.sv
// Rotating first-set-bit encoder: the pointer names the highest-priority channel.
module dma_priority_encoder
    import dma_arb_pkg::*;
(
    input  logic [CHANNELS-1:0] pending_i,
    input  logic [SEL_W-1:0]    pointer_i,
    output logic [SEL_W-1:0]    winner_o,
    output logic                valid_o
);
    logic [2*CHANNELS-1:0] doubled;
    logic [CHANNELS-1:0]   rotated;
    logic [SEL_W-1:0]      offset;

    // rotated[i] is pending[(pointer + i) mod CHANNELS]
    assign doubled = {pending_i, pending_i};
    assign rotated = doubled[pointer_i +: CHANNELS];

    always_comb begin
        offset = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                offset = SEL_W'(i);
            end
        end
    end

    assign valid_o  = |pending_i;
    // SEL_W-bit add wraps modulo CHANNELS because CHANNELS is a power of two
    assign winner_o = offset + pointer_i;
endmodule

// File: rtl/dma_priority_arbiter.sv
// DMA channel arbiter and HRQ/HLDA bus-request sequencer.
// Rotating priority is built only when DMA_ROTATING_PRIORITY_EN is defined.
module dma_priority_arbiter
    import dma_arb_pkg::*;
(
    input  logic                CLK,
    input  logic                RESET_N,
    input  logic [CHANNELS-1:0] DREQ,
    input  logic [CHANNELS-1:0] mask,
    input  logic                controllerDisable,
    input  logic                rotateEn,
    input  logic                HLDA,
    input  logic                EOP_N,
    output logic                HRQ,
    output logic [CHANNELS-1:0] DACK,
    output logic [SEL_W-1:0]    activeChannel,
    output logic                grantValid,
    output arbState_t           dbg_state_o,
    output logic [SEL_W-1:0]    dbg_pointer_o
);
    arbState_t           state_q, state_d;
    logic [SEL_W-1:0]    ch_q, ch_d;
    logic [SEL_W-1:0]    ptr_q, ptr_eff;
    logic [CHANNELS-1:0] pending;
    logic [SEL_W-1:0]    win_idx;
    logic                win_valid;
    logic                grant_exit;

    // Disable only blocks the start of a new bus request; REQ/GRANT ignore it.
    assign pending = (state_q == IDLE && controllerDisable) ? '0 : (DREQ & ~mask);

    dma_priority_encoder u_enc (
        .pending_i (pending),
        .pointer_i (ptr_eff),
        .winner_o  (win_idx),
        .valid_o   (win_valid)
    );

    // Normal end of grant; an HLDA drop is an abort and takes precedence.
    assign grant_exit = (state_q == GRANT) && HLDA &&
                        (!EOP_N || !DREQ[ch_q] || mask[ch_q]);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            ch_q    <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        case (state_q)
            IDLE: begin
                if (win_valid) state_d = REQ;
            end
            REQ: begin
                if (!win_valid) begin
                    state_d = RELEASE;
                end else if (HLDA) begin
                    state_d = GRANT;
                    ch_d    = win_idx;
                end
            end
            GRANT: begin
                if (!HLDA) state_d = IDLE;
                else if (grant_exit) state_d = RELEASE;
            end
            RELEASE: begin
                if (!HLDA) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef DMA_ROTATING_PRIORITY_EN
    logic [SEL_W-1:0] ptr_d;

    // The just-served channel becomes lowest priority; aborts leave it alone.
    always_comb begin
        ptr_d = ptr_q;
        if (grant_exit && rotateEn) ptr_d = ch_q + SEL_W'(1);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) ptr_q <= '0;
        else          ptr_q <= ptr_d;
    end

    assign ptr_eff = rotateEn ? ptr_q : '0;
`else
    logic unused_rotate_en;

    assign ptr_q            = '0;
    assign ptr_eff          = '0;
    assign unused_rotate_en = rotateEn;
`endif

    always_comb begin
        HRQ           = 1'b0;
        DACK          = '0;
        activeChannel = '0;
        grantValid    = 1'b0;
        case (state_q)
            REQ: HRQ = 1'b1;
            GRANT: begin
                HRQ           = 1'b1;
                DACK[ch_q]    = 1'b1;
                activeChannel = ch_q;
                grantValid    = 1'b1;
            end
            default: ;
        endcase
    end

    assign dbg_state_o   = state_q;
    assign dbg_pointer_o = ptr_q;
endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Self-checking bench for dma_priority_arbiter: cycle vectors scored through an expected queue.
module tb_dma_priority_arbiter;
    import dma_arb_pkg::*;

    localparam int W = 8;  // {HRQ, DACK[3:0], activeChannel[1:0], grantValid}

    typedef struct {
        logic [3:0]   dreq;
        logic [3:0]   msk;
        logic         dis;
        logic         rot;
        logic         hlda;
        logic         eop_n;
        logic [W-1:0] exp;
    } vec_t;

    logic                CLK;
    logic                RESET_N;
    logic [CHANNELS-1:0] DREQ;
    logic [CHANNELS-1:0] mask;
    logic                controllerDisable;
    logic                rotateEn;
    logic                HLDA;
    logic                EOP_N;
    logic                HRQ;
    logic [CHANNELS-1:0] DACK;
    logic [SEL_W-1:0]    activeChannel;
    logic                grantValid;
    arbState_t           dbg_state;
    logic [SEL_W-1:0]    dbg_pointer;

    logic [W-1:0] exp_q[$];
    string        tag_q[$];
    int           checks = 0;
    int           errors = 0;

    dma_priority_arbiter dut (
        .CLK               (CLK),
        .RESET_N           (RESET_N),
        .DREQ              (DREQ),
        .mask              (mask),
        .controllerDisable (controllerDisable),
        .rotateEn          (rotateEn),
        .HLDA              (HLDA),
        .EOP_N             (EOP_N),
        .HRQ               (HRQ),
        .DACK              (DACK),
        .activeChannel     (activeChannel),
        .grantValid        (grantValid),
        .dbg_state_o       (dbg_state),
        .dbg_pointer_o     (dbg_pointer)
    );

    // clock / reset
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic logic [W-1:0] g(input int ch);
        logic [3:0] oh;
        logic [1:0] a;
        oh = 4'b0001 << ch;
        a  = 2'(ch);
        return {1'b1, oh, a, 1'b1};
    endfunction

    function automatic vec_t mk(input logic [3:0] d, input logic [3:0] m, input logic dis,
                                input logic rot, input logic hlda, input logic eop,
                                input logic [W-1:0] e);
        vec_t v;
        v.dreq = d; v.msk = m; v.dis = dis; v.rot = rot;
        v.hlda = hlda; v.eop_n = eop; v.exp = e;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // scoreboard: compare outputs produced by the previous edge
    task automatic sb_check();
        logic [W-1:0] act;
        logic [W-1:0] e;
        string        t;
        logic         legal;
        act   = {HRQ, DACK, activeChannel, grantValid};
        legal = ($countones(DACK) <= 1) && !(|DACK && !HRQ);
        check("dack_legal", 32'(legal), 32'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check(t, 32'(act), 32'(e));
        end
    endtask

    // driver
    task automatic step(input vec_t v, input string tag);
        @(negedge CLK);
        sb_check();
        DREQ              = v.dreq;
        mask              = v.msk;
        controllerDisable = v.dis;
        rotateEn          = v.rot;
        HLDA              = v.hlda;
        EOP_N             = v.eop_n;
        exp_q.push_back(v.exp);
        tag_q.push_back(tag);
    endtask

    task automatic flush();
        @(negedge CLK);
        sb_check();
    endtask

    localparam logic [W-1:0] Z = 8'h00;
    localparam logic [W-1:0] R = 8'h80;

    vec_t tbl[32];
    int   rot_ch;
    int   exp_ptr;

    initial begin
        RESET_N = 1'b0; DREQ = '0; mask = '0; controllerDisable = 1'b0;
        rotateEn = 1'b0; HLDA = 1'b0; EOP_N = 1'b1;

        // fixed priority, mask/disable, withdrawal, simultaneous requests
        tbl[0]  = mk(4'b1010, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, R);
        tbl[1]  = mk(4'b1010, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, R);
        tbl[2]  = mk(4'b1010, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, g(1));
        tbl[3]  = mk(4'b1010, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, g(1));
        tbl[4]  = mk(4'b1000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, Z);
        tbl[5]  = mk(4'b1000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, Z);
        tbl[6]  = mk(4'b1000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, Z);
        tbl[7]  = mk(4'b1000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, R);
        tbl[8]  = mk(4'b1000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, g(3));
        tbl[9]  = mk(4'b1000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, Z);
        tbl[10] = mk(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, Z);
        tbl[11] = mk(4'b0001, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b1, Z);
        tbl[12] = mk(4'b0001, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b1, Z);
        tbl[13] = mk(4'b0100, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, Z);
        tbl[14] = mk(4'b0100, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, Z);
        tbl[15] = mk(4'b0100, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, R);
        tbl[16] = mk(4'b0100, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, g(2));
        tbl[17] = mk(4'b0100, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b1, g(2));
        tbl[18] = mk(4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b1, Z);
        tbl[19] = mk(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, Z);
        tbl[20] = mk(4'b0100, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, R);
        tbl[21] = mk(4'b0100, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, R);
        tbl[22] = mk(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, Z);
        tbl[23] = mk(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, Z);
        tbl[24] = mk(4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, R);
        tbl[25] = mk(4'b1111, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, g(0));
        tbl[26] = mk(4'b1111, 4'b0001, 1'b0, 1'b0, 1'b1, 1'b1, Z);
        tbl[27] = mk(4'b1111, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b1, Z);
        tbl[28] = mk(4'b1111, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b1, R);
        tbl[29] = mk(4'b1111, 4'b0001, 1'b0, 1'b0, 1'b1, 1'b1, g(1));
        tbl[30] = mk(4'b1111, 4'b0001, 1'b0, 1'b0, 1'b1, 1'b0, Z);
        tbl[31] = mk(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, Z);

        repeat (2) @(negedge CLK);
        check("rst_outputs", 32'({HRQ, DACK, activeChannel, grantValid}), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        check("rst_pointer", 32'(dbg_pointer), 32'd0);
        RESET_N = 1'b1;

        for (int i = 0; i < 32; i++) step(tbl[i], $sformatf("vec%0d", i));
        check("ptr_after_fixed", 32'(dbg_pointer), 32'd0);

        // rotating priority: five grants with all channels requesting
        for (int k = 0; k < 5; k++) begin
`ifdef DMA_ROTATING_PRIORITY_EN
            rot_ch = k % 4;
`else
            rot_ch = 0;
`endif
            step(mk(4'b1111, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1, R), $sformatf("rot%0d_req", k));
            step(mk(4'b1111, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b1, g(rot_ch)), $sformatf("rot%0d_grant", k));
            step(mk(4'b1111, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, Z), $sformatf("rot%0d_eop", k));
            step(mk(4'b1111, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1, Z), $sformatf("rot%0d_idle", k));
        end
`ifdef DMA_ROTATING_PRIORITY_EN
        exp_ptr = 1;
`else
        exp_ptr = 0;
`endif
        check("ptr_after_rot", 32'(dbg_pointer), 32'(exp_ptr));

        // abort: HLDA drops together with EOP_N in GRANT
        step(mk(4'b1111, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1, R), "abort_req");
        step(mk(4'b1111, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b1, g(exp_ptr)), "abort_grant");
        step(mk(4'b1111, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, Z), "abort_out");
        step(mk(4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1, Z), "abort_idle");
        check("abort_state", 32'(dbg_state), 32'(IDLE));
        check("abort_ptr", 32'(dbg_pointer), 32'(exp_ptr));

        // asynchronous reset while channel 2 holds the bus
        step(mk(4'b0100, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1, R), "rstg_req");
        step(mk(4'b0100, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b1, g(2)), "rstg_grant");
        flush();
        #2 RESET_N = 1'b0;
        #1;
        check("rstg_outputs", 32'({HRQ, DACK, activeChannel, grantValid}), 32'd0);
        check("rstg_state", 32'(dbg_state), 32'(IDLE));
        check("rstg_pointer", 32'(dbg_pointer), 32'd0);
        DREQ = '0; HLDA = 1'b0; rotateEn = 1'b0;
        @(negedge CLK);
        RESET_N = 1'b1;
        repeat (2) @(negedge CLK);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
